// File: rtl/control_sequencer_pkg.sv
// Shared nic8 sequencer definitions: src/dst codes, HALT opcode, FSM state
// encodings and the control-word layout shared with the register file.
package control_sequencer_pkg;

  localparam logic [2:0] SRC_ALU = 3'd0;
  localparam logic [2:0] SRC_A   = 3'd1;
  localparam logic [2:0] SRC_X   = 3'd2;
  localparam logic [2:0] SRC_ROM = 3'd3;
  localparam logic [2:0] SRC_RAM = 3'd4;

  localparam logic [2:0] DST_A   = 3'd0;
  localparam logic [2:0] DST_B   = 3'd1;
  localparam logic [2:0] DST_X   = 3'd2;
  localparam logic [2:0] DST_Q   = 3'd3;
  localparam logic [2:0] DST_PC  = 3'd4;
  localparam logic [2:0] DST_RAM = 3'd5;
  localparam logic [2:0] DST_JZ  = 3'd6;
  localparam logic [2:0] DST_JC  = 3'd7;

  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Field order mirrors the register file's control-word unpacking.
  typedef struct packed {
    logic load_ir;
    logic load_a;
    logic load_b;
    logic load_x;
    logic load_q;
    logic load_pc;
    logic load_mem;
    logic inc_pc;
    logic assert_bar_a;
    logic assert_bar_x;
    logic assert_bar_rom;
    logic assert_bar_alu;
    logic assert_bar_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 13'b0000000_0_11111;

  function automatic logic is_halt(input logic [7:0] ir);
    return ir == OP_HALT;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath/register file (slave).
interface control_sequencer_if #(parameter int COUNT_W = 16);
  logic               run;
  logic [7:0]         dbus;
  logic               zero_flag;
  logic               carry_flag;
  logic               load_ir;
  logic               load_a;
  logic               load_b;
  logic               load_x;
  logic               load_q;
  logic               load_pc;
  logic               load_mem;
  logic               inc_pc;
  logic               assert_bar_a;
  logic               assert_bar_x;
  logic               assert_bar_rom;
  logic               assert_bar_alu;
  logic               assert_bar_ram;
  logic [1:0]         alu_op;
  logic               halted;
  logic [7:0]         ir;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  run, dbus, zero_flag, carry_flag,
    output load_ir, load_a, load_b, load_x, load_q, load_pc, load_mem, inc_pc,
           assert_bar_a, assert_bar_x, assert_bar_rom, assert_bar_alu, assert_bar_ram,
           alu_op, halted, ir, instr_count
  );

  modport slave (
    output run, dbus, zero_flag, carry_flag,
    input  load_ir, load_a, load_b, load_x, load_q, load_pc, load_mem, inc_pc,
           assert_bar_a, assert_bar_x, assert_bar_rom, assert_bar_alu, assert_bar_ram,
           alu_op, halted, ir, instr_count
  );
endinterface

// File: rtl/control_sequencer_seq_decode.sv
// Combinational decode of {state, ir, flags, run} into load strobes and
// active-low bus enables; only one src case can fire, so one driver at most.
module control_sequencer_seq_decode
  import control_sequencer_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [7:0] i_ir,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_run,
  output ctrl_t      o_ctrl
);

  logic [2:0] w_src;
  logic [2:0] w_dst;

  assign w_src = i_ir[7:5];
  assign w_dst = i_ir[4:2];

  always_comb begin
    o_ctrl = CTRL_IDLE;
    if (i_run) begin
      case (i_state)
        ST_FETCH: begin
          o_ctrl.assert_bar_rom = 1'b0;
          o_ctrl.load_ir        = 1'b1;
          o_ctrl.inc_pc         = 1'b1;
        end
        ST_EXEC: begin
          // src 5..7 (HALT included) is a NOP: no driver and no destination load
          if (!is_halt(i_ir) && w_src <= SRC_RAM) begin
            case (w_src)
              SRC_ALU: o_ctrl.assert_bar_alu = 1'b0;
              SRC_A:   o_ctrl.assert_bar_a   = 1'b0;
              SRC_X:   o_ctrl.assert_bar_x   = 1'b0;
              SRC_ROM: begin
                o_ctrl.assert_bar_rom = 1'b0;
                o_ctrl.inc_pc         = 1'b1;
              end
              default: o_ctrl.assert_bar_ram = 1'b0;
            endcase
            case (w_dst)
              DST_A:   o_ctrl.load_a   = 1'b1;
              DST_B:   o_ctrl.load_b   = 1'b1;
              DST_X:   o_ctrl.load_x   = 1'b1;
              DST_Q:   o_ctrl.load_q   = 1'b1;
              DST_PC:  o_ctrl.load_pc  = 1'b1;
              DST_RAM: o_ctrl.load_mem = 1'b1;
              DST_JZ:  o_ctrl.load_pc  = i_zero;
              default: o_ctrl.load_pc  = i_carry;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: holds the FSM, instruction register and retired
// count; strobes come from registered state/ir only, never from dbus directly.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.master  bus
);

  logic [1:0]         r_state;
  logic [7:0]         r_ir;
  logic [COUNT_W-1:0] r_count;
  ctrl_t              w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= 8'h00;
      r_count <= '0;
    end else if (bus.run) begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= bus.dbus;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_halt(r_ir)) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_FETCH;
            r_count <= r_count + COUNT_W'(1);
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  control_sequencer_seq_decode u_decode (
    .i_state (r_state),
    .i_ir    (r_ir),
    .i_zero  (bus.zero_flag),
    .i_carry (bus.carry_flag),
    .i_run   (bus.run),
    .o_ctrl  (w_ctrl)
  );

  assign bus.load_ir        = w_ctrl.load_ir;
  assign bus.load_a         = w_ctrl.load_a;
  assign bus.load_b         = w_ctrl.load_b;
  assign bus.load_x         = w_ctrl.load_x;
  assign bus.load_q         = w_ctrl.load_q;
  assign bus.load_pc        = w_ctrl.load_pc;
  assign bus.load_mem       = w_ctrl.load_mem;
  assign bus.inc_pc         = w_ctrl.inc_pc;
  assign bus.assert_bar_a   = w_ctrl.assert_bar_a;
  assign bus.assert_bar_x   = w_ctrl.assert_bar_x;
  assign bus.assert_bar_rom = w_ctrl.assert_bar_rom;
  assign bus.assert_bar_alu = w_ctrl.assert_bar_alu;
  assign bus.assert_bar_ram = w_ctrl.assert_bar_ram;
  assign bus.alu_op         = r_ir[1:0];
  assign bus.halted         = (r_state == ST_HALT);
  assign bus.ir             = r_ir;
  assign bus.instr_count    = r_count;

endmodule
